// File: rtl/tetris_pkg.sv
// Shared definitions for the tetris board: playfield geometry, cell codes,
// line-clear FSM state encoding, the points table and a row-full helper.
package tetris_pkg;

    localparam int COLS   = 10;
    localparam int ROWS   = 20;
    localparam int KIND_W = 4;
    localparam int ROW_W  = COLS * KIND_W;
    localparam int X_W    = 4;
    localparam int Y_W    = 5;
    localparam int CNT_W  = 3;

    localparam logic [KIND_W-1:0] KIND_EMPTY = 4'd0;
    localparam logic [X_W-1:0]    COLS_X     = 4'd10;
    localparam logic [Y_W-1:0]    ROWS_Y     = 5'd20;
    localparam logic [Y_W-1:0]    LAST_ROW   = 5'd19;
    localparam logic [CNT_W-1:0]  CNT_MAX    = 3'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Points per pass indexed by rows cleared; any count of 4 or more scores 8.
    function automatic logic [3:0] pts(input logic [CNT_W-1:0] cnt);
        logic [3:0] p;
        case (cnt)
            3'd0:    p = 4'd0;
            3'd1:    p = 4'd1;
            3'd2:    p = 4'd3;
            3'd3:    p = 4'd5;
            default: p = 4'd8;
        endcase
        return p;
    endfunction

    // A row is full when every cell in it holds a non-empty code.
    function automatic logic row_full(input logic [ROW_W-1:0] row);
        logic full;
        full = 1'b1;
        for (int c = 0; c < COLS; c++) begin
            full = full & (row[c*KIND_W +: KIND_W] != KIND_EMPTY);
        end
        return full;
    endfunction

endpackage

// File: rtl/tetris_board_if.sv
// Game-logic side of the board: cell write handshake and lock handshake.
//  master : game FSM (drives valids and write payload)
//  slave  : tetris_board (drives the readies)
interface tetris_board_if;
    import tetris_pkg::*;

    logic              wr_valid;
    logic              wr_ready;
    logic [X_W-1:0]    wr_x;
    logic [Y_W-1:0]    wr_y;
    logic [KIND_W-1:0] wr_kind;
    logic              lock_valid;
    logic              lock_ready;

    modport master (
        output wr_valid, wr_x, wr_y, wr_kind, lock_valid,
        input  wr_ready, lock_ready
    );

    modport slave (
        input  wr_valid, wr_x, wr_y, wr_kind, lock_valid,
        output wr_ready, lock_ready
    );

endinterface

// File: rtl/tetris_board_bcd_add_sat.sv
// Combinational 4-digit BCD plus 4-bit binary adder, saturating at 9999.
//  bcd_in  : current score, 4 BCD digits, [15:12] = thousands
//  bin_in  : binary increment (0..15)
//  bcd_out : bcd_in + bin_in in BCD, clamped to 9999 on overflow
// The ones digit can reach 9+15=24, so the carry into the next digit may be 2.
module bcd_add_sat (
    input  logic [15:0] bcd_in,
    input  logic [3:0]  bin_in,
    output logic [15:0] bcd_out
);

    logic [5:0]  sum;
    logic [4:0]  carry;
    logic [15:0] res;

    // Ripple the addend through the four digits with decimal correction.
    always_comb begin
        carry = {1'b0, bin_in};
        sum   = 6'd0;
        res   = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            sum = {2'b00, bcd_in[4*i +: 4]} + {1'b0, carry};
            if (sum >= 6'd20) begin
                res[4*i +: 4] = 4'(sum - 6'd20);
                carry         = 5'd2;
            end else if (sum >= 6'd10) begin
                res[4*i +: 4] = 4'(sum - 6'd10);
                carry         = 5'd1;
            end else begin
                res[4*i +: 4] = sum[3:0];
                carry         = 5'd0;
            end
        end
        if (carry != 5'd0) begin
            bcd_out = 16'h9999;
        end else begin
            bcd_out = res;
        end
    end

endmodule

// File: rtl/tetris_board.sv
// Owner of the 10x20 playfield and the BCD score.
//  clk, reset_n   : clock, synchronous active-low reset
//  rd_x, rd_y     : display cell query; rd_kind returns the code (combinational)
//  score_bcd      : 4-digit BCD score
//  bus (slave)    : cell write handshake and lock handshake from game logic
//  clear_board    : synchronous wipe of board, score and FSM
//  busy           : FSM not in IDLE
//  clear_done     : one-cycle pulse at the end of a line-clear pass
//  lines_cleared  : rows removed by the last pass, held until the next pass ends
// A lock starts a bottom-up scan. A full row is collapsed one row per cycle
// (everything above drops by one, row 0 is emptied), then the same row index
// is re-scanned because it now holds what was above it.
module tetris_board
    import tetris_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [X_W-1:0]    rd_x,
    input  logic [Y_W-1:0]    rd_y,
    output logic [KIND_W-1:0] rd_kind,
    output logic [15:0]       score_bcd,
    tetris_board_if.slave     bus,
    input  logic              clear_board,
    output logic              busy,
    output logic              clear_done,
    output logic [CNT_W-1:0]  lines_cleared
);

    logic [ROW_W-1:0] board_r [ROWS];

    state_t           state_r,  state_s;
    logic [Y_W-1:0]   row_r,    row_s;
    logic [Y_W-1:0]   k_r,      k_s;
    logic [CNT_W-1:0] cnt_r,    cnt_s;

    logic [15:0]      score_r;
    logic [15:0]      score_sum_s;
    logic             clear_done_r;
    logic [CNT_W-1:0] lines_cleared_r;

    logic             wipe_s;
    logic             idle_s;
    logic             wr_fire_s;
    logic             wr_in_range_s;
    logic             lock_fire_s;
    logic             scan_full_s;
    logic [KIND_W-1:0] rd_kind_s;

    assign wipe_s        = ~reset_n | clear_board;
    assign idle_s        = (state_r == IDLE);
    assign wr_fire_s     = bus.wr_valid & idle_s;
    assign lock_fire_s   = bus.lock_valid & idle_s;
    assign wr_in_range_s = (bus.wr_x < COLS_X) && (bus.wr_y < ROWS_Y);
    // row_r only ever holds 0..ROWS-1, so this lookup is always in range.
    assign scan_full_s   = row_full(board_r[row_r]);

    assign bus.wr_ready   = idle_s;
    assign bus.lock_ready = idle_s;
    assign busy           = ~idle_s;
    assign score_bcd      = score_r;
    assign clear_done     = clear_done_r;
    assign lines_cleared  = lines_cleared_r;
    assign rd_kind        = rd_kind_s;

    bcd_add_sat u_bcd_add_sat (
        .bcd_in  (score_r),
        .bin_in  (pts(cnt_r)),
        .bcd_out (score_sum_s)
    );

    // Display read port: out-of-range coordinates read as empty.
    always_comb begin
        rd_kind_s = KIND_EMPTY;
        if ((rd_x < COLS_X) && (rd_y < ROWS_Y)) begin
            rd_kind_s = board_r[rd_y][rd_x*KIND_W +: KIND_W];
        end else begin
            rd_kind_s = KIND_EMPTY;
        end
    end

    // Line-clear FSM next-state and counter logic.
    always_comb begin
        state_s = state_r;
        row_s   = row_r;
        k_s     = k_r;
        cnt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (lock_fire_s) begin
                    state_s = SCAN;
                    row_s   = LAST_ROW;
                    cnt_s   = 3'd0;
                end else begin
                    state_s = IDLE;
                end
            end
            SCAN: begin
                if (scan_full_s) begin
                    state_s = SHIFT;
                    k_s     = row_r;
                end else if (row_r == 5'd0) begin
                    state_s = DONE;
                end else begin
                    row_s   = row_r - 5'd1;
                end
            end
            SHIFT: begin
                if (k_r == 5'd0) begin
                    state_s = SCAN;
                    cnt_s   = (cnt_r >= CNT_MAX) ? CNT_MAX : cnt_r + 3'd1;
                end else begin
                    k_s     = k_r - 5'd1;
                end
            end
            DONE: begin
                state_s = IDLE;
                cnt_s   = 3'd0;
            end
            default: begin
                state_s = IDLE;
                cnt_s   = 3'd0;
            end
        endcase
    end

    // FSM state and scan/shift/count registers.
    always_ff @(posedge clk) begin
        if (wipe_s) begin
            state_r <= IDLE;
            row_r   <= 5'd0;
            k_r     <= 5'd0;
            cnt_r   <= 3'd0;
        end else begin
            state_r <= state_s;
            row_r   <= row_s;
            k_r     <= k_s;
            cnt_r   <= cnt_s;
        end
    end

    // Board storage: wipe, game writes in IDLE, and one-row-per-cycle collapse.
    always_ff @(posedge clk) begin
        if (wipe_s) begin
            for (int r = 0; r < ROWS; r++) begin
                board_r[r] <= '0;
            end
        end else if (wr_fire_s && wr_in_range_s) begin
            board_r[bus.wr_y][bus.wr_x*KIND_W +: KIND_W] <= bus.wr_kind;
        end else if (state_r == SHIFT) begin
            if (k_r == 5'd0) begin
                board_r[0] <= '0;
            end else begin
                board_r[k_r] <= board_r[k_r - 5'd1];
            end
        end else begin
            board_r[0] <= board_r[0];
        end
    end

    // Score and end-of-pass result registers.
    always_ff @(posedge clk) begin
        if (wipe_s) begin
            score_r         <= 16'h0000;
            clear_done_r    <= 1'b0;
            lines_cleared_r <= 3'd0;
        end else if (state_r == DONE) begin
            score_r         <= score_sum_s;
            clear_done_r    <= 1'b1;
            lines_cleared_r <= cnt_r;
        end else begin
            clear_done_r    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tetris_board.sv
// Directed testbench for tetris_board: table-driven cell write/read vectors,
// a BCD adder vector table, and hand-written multi-cycle line-clear sequences.
module tb_tetris_board;
    import tetris_pkg::*;

    logic        clk;
    logic        reset_n;
    logic [3:0]  rd_x;
    logic [4:0]  rd_y;
    logic [3:0]  rd_kind;
    logic [15:0] score_bcd;
    logic        clear_board;
    logic        busy;
    logic        clear_done;
    logic [2:0]  lines_cleared;

    int errors = 0;
    int checks = 0;

    tetris_board_if bus ();

    tetris_board dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .rd_x          (rd_x),
        .rd_y          (rd_y),
        .rd_kind       (rd_kind),
        .score_bcd     (score_bcd),
        .bus           (bus),
        .clear_board   (clear_board),
        .busy          (busy),
        .clear_done    (clear_done),
        .lines_cleared (lines_cleared)
    );

    logic [15:0] ba_in;
    logic [3:0]  ba_bin;
    logic [15:0] ba_out;

    bcd_add_sat u_bcd (
        .bcd_in  (ba_in),
        .bin_in  (ba_bin),
        .bcd_out (ba_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] x;
        logic [4:0] y;
        logic [3:0] kind;
        logic [3:0] exp;
    } wr_vec_t;

    typedef struct {
        logic [15:0] a;
        logic [3:0]  b;
        logic [15:0] exp;
    } bcd_vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic write_cell(input logic [3:0] x, input logic [4:0] y, input logic [3:0] k);
        @(negedge clk);
        bus.wr_valid = 1'b1;
        bus.wr_x     = x;
        bus.wr_y     = y;
        bus.wr_kind  = k;
        @(negedge clk);
        bus.wr_valid = 1'b0;
    endtask

    task automatic fill_row(input logic [4:0] y, input logic [3:0] k);
        for (int x = 0; x < 10; x++) begin
            write_cell(4'(x), y, k);
        end
    endtask

    task automatic read_cell(input logic [3:0] x, input logic [4:0] y, output logic [3:0] k);
        rd_x = x;
        rd_y = y;
        #1;
        k = rd_kind;
    endtask

    task automatic count_nonzero(input int y_lo, input int y_hi, output int n);
        logic [3:0] k;
        n = 0;
        for (int y = y_lo; y <= y_hi; y++) begin
            for (int x = 0; x < 10; x++) begin
                read_cell(4'(x), 5'(y), k);
                if (k != 4'd0) n++;
            end
        end
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear_board = 1'b1;
        @(negedge clk);
        clear_board = 1'b0;
    endtask

    // Lock (optionally with a simultaneous write) and count cycles from the
    // accepting edge to the edge after which clear_done is high.
    task automatic do_lock(input bit with_wr, input logic [3:0] x, input logic [4:0] y,
                           input logic [3:0] k, output int lat);
        @(negedge clk);
        bus.lock_valid = 1'b1;
        if (with_wr) begin
            bus.wr_valid = 1'b1;
            bus.wr_x     = x;
            bus.wr_y     = y;
            bus.wr_kind  = k;
        end
        @(posedge clk);
        #1;
        bus.lock_valid = 1'b0;
        bus.wr_valid   = 1'b0;
        lat = 0;
        while (lat < 400) begin
            @(posedge clk);
            lat++;
            #1;
            if (clear_done) break;
        end
    endtask

    initial begin
        wr_vec_t  wv [10];
        bcd_vec_t bv [11];
        logic [3:0] k;
        int n;
        int lat;
        int acc;
        bit early_bad;
        bit done_seen;

        wv[0] = '{x: 4'd0,  y: 5'd0,  kind: 4'd3, exp: 4'd3};
        wv[1] = '{x: 4'd9,  y: 5'd19, kind: 4'd7, exp: 4'd7};
        wv[2] = '{x: 4'd5,  y: 5'd10, kind: 4'd1, exp: 4'd1};
        wv[3] = '{x: 4'd10, y: 5'd0,  kind: 4'd5, exp: 4'd0};
        wv[4] = '{x: 4'd0,  y: 5'd20, kind: 4'd6, exp: 4'd0};
        wv[5] = '{x: 4'd15, y: 5'd31, kind: 4'd2, exp: 4'd0};
        wv[6] = '{x: 4'd9,  y: 5'd0,  kind: 4'd4, exp: 4'd4};
        wv[7] = '{x: 4'd5,  y: 5'd10, kind: 4'd0, exp: 4'd0};
        wv[8] = '{x: 4'd3,  y: 5'd7,  kind: 4'd15, exp: 4'd15};
        wv[9] = '{x: 4'd9,  y: 5'd20, kind: 4'd1, exp: 4'd0};

        bv[0]  = '{a: 16'h0000, b: 4'd0, exp: 16'h0000};
        bv[1]  = '{a: 16'h0001, b: 4'd8, exp: 16'h0009};
        bv[2]  = '{a: 16'h0009, b: 4'd1, exp: 16'h0010};
        bv[3]  = '{a: 16'h0099, b: 4'd3, exp: 16'h0102};
        bv[4]  = '{a: 16'h0999, b: 4'd5, exp: 16'h1004};
        bv[5]  = '{a: 16'h9995, b: 4'd8, exp: 16'h9999};
        bv[6]  = '{a: 16'h9999, b: 4'd1, exp: 16'h9999};
        bv[7]  = '{a: 16'h9991, b: 4'd8, exp: 16'h9999};
        bv[8]  = '{a: 16'h1234, b: 4'd5, exp: 16'h1239};
        bv[9]  = '{a: 16'h0008, b: 4'd8, exp: 16'h0016};
        bv[10] = '{a: 16'h9990, b: 4'd8, exp: 16'h9998};

        reset_n        = 1'b0;
        clear_board    = 1'b0;
        rd_x           = 4'd0;
        rd_y           = 5'd0;
        bus.wr_valid   = 1'b0;
        bus.wr_x       = 4'd0;
        bus.wr_y       = 5'd0;
        bus.wr_kind    = 4'd0;
        bus.lock_valid = 1'b0;
        ba_in          = 16'h0000;
        ba_bin         = 4'd0;

        // BCD adder vectors, including saturation near 9999.
        for (int i = 0; i < 11; i++) begin
            ba_in  = bv[i].a;
            ba_bin = bv[i].b;
            #1;
            check($sformatf("bcd_add[%0d]", i), 32'(ba_out), 32'(bv[i].exp));
        end

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy",  32'(busy), 32'd0);
        check("reset_score", 32'(score_bcd), 32'h0000);
        check("reset_done",  32'(clear_done), 32'd0);
        check("reset_lines", 32'(lines_cleared), 32'd0);
        check("reset_ready", 32'({bus.wr_ready, bus.lock_ready}), 32'd3);
        reset_n = 1'b1;
        count_nonzero(0, 19, n);
        check("reset_board_empty", 32'(n), 32'd0);

        // Write/read table, including out-of-range writes and queries.
        for (int i = 0; i < 10; i++) begin
            write_cell(wv[i].x, wv[i].y, wv[i].kind);
            read_cell(wv[i].x, wv[i].y, k);
            check($sformatf("wr_rd[%0d]", i), 32'(k), 32'(wv[i].exp));
        end
        read_cell(4'd10, 5'd19, k);
        check("rd_x_oob", 32'(k), 32'd0);
        read_cell(4'd9, 5'd20, k);
        check("rd_y_oob", 32'(k), 32'd0);
        count_nonzero(0, 19, n);
        check("table_cell_count", 32'(n), 32'd4);

        pulse_clear();
        count_nonzero(0, 19, n);
        check("clear_board_empty", 32'(n), 32'd0);

        // Empty board lock: pure scan latency.
        do_lock(1'b0, 4'd0, 5'd0, 4'd0, lat);
        check("lat_empty", 32'(lat), 32'd21);
        check("lines_empty", 32'(lines_cleared), 32'd0);
        check("score_empty", 32'(score_bcd), 32'h0000);

        // Single line at the bottom with a block resting on it.
        fill_row(5'd19, 4'd1);
        write_cell(4'd0, 5'd18, 4'd2);
        do_lock(1'b0, 4'd0, 5'd0, 4'd0, lat);
        check("lat_one", 32'(lat), 32'd42);
        check("lines_one", 32'(lines_cleared), 32'd1);
        check("score_one", 32'(score_bcd), 32'h0001);
        read_cell(4'd0, 5'd19, k);
        check("cell_19_0", 32'(k), 32'd2);
        read_cell(4'd1, 5'd19, k);
        check("cell_19_1", 32'(k), 32'd0);
        read_cell(4'd0, 5'd18, k);
        check("cell_18_0", 32'(k), 32'd0);
        count_nonzero(0, 0, n);
        check("row0_empty", 32'(n), 32'd0);
        @(negedge clk);
        check("done_one_cycle", 32'(clear_done), 32'd0);
        check("lines_hold", 32'(lines_cleared), 32'd1);

        // Four-line clear from a clean board.
        pulse_clear();
        for (int y = 16; y < 20; y++) fill_row(5'(y), 4'(y - 13));
        do_lock(1'b0, 4'd0, 5'd0, 4'd0, lat);
        check("lat_four", 32'(lat), 32'd105);
        check("lines_four", 32'(lines_cleared), 32'd4);
        check("score_four", 32'(score_bcd), 32'h0008);
        count_nonzero(0, 19, n);
        check("four_board_empty", 32'(n), 32'd0);

        // Second four-line pass: BCD carry 8 + 8 = 16.
        for (int y = 16; y < 20; y++) fill_row(5'(y), 4'd5);
        do_lock(1'b0, 4'd0, 5'd0, 4'd0, lat);
        check("lines_four_b", 32'(lines_cleared), 32'd4);
        check("score_16", 32'(score_bcd), 32'h0016);

        // Final cell written in the same cycle as the lock completes the row.
        for (int x = 0; x < 9; x++) write_cell(4'(x), 5'd19, 4'd3);
        do_lock(1'b1, 4'd9, 5'd19, 4'd3, lat);
        check("lat_wr_lock", 32'(lat), 32'd42);
        check("lines_wr_lock", 32'(lines_cleared), 32'd1);
        check("score_17", 32'(score_bcd), 32'h0017);

        // Write held through the collapse: not accepted until IDLE.
        fill_row(5'd19, 4'd2);
        @(negedge clk);
        bus.lock_valid = 1'b1;
        @(negedge clk);
        bus.lock_valid = 1'b0;
        @(negedge clk);
        check("busy_in_shift", 32'(busy), 32'd1);
        check("wr_ready_shift", 32'(bus.wr_ready), 32'd0);
        rd_x        = 4'd3;
        rd_y        = 5'd5;
        bus.wr_x    = 4'd3;
        bus.wr_y    = 5'd5;
        bus.wr_kind = 4'd6;
        bus.wr_valid = 1'b1;
        acc = 0;
        early_bad = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.wr_ready) begin
                acc++;
                @(negedge clk);
                bus.wr_valid = 1'b0;
                break;
            end else if (rd_kind != 4'd0) begin
                early_bad = 1'b1;
            end
        end
        bus.wr_valid = 1'b0;
        check("held_wr_accepted", 32'(acc), 32'd1);
        check("held_wr_not_early", 32'(early_bad), 32'd0);
        read_cell(4'd3, 5'd5, k);
        check("held_wr_cell", 32'(k), 32'd6);
        check("held_wr_lines", 32'(lines_cleared), 32'd1);
        check("score_18", 32'(score_bcd), 32'h0018);

        // clear_board in the middle of a collapse.
        fill_row(5'd19, 4'd4);
        @(negedge clk);
        bus.lock_valid = 1'b1;
        @(negedge clk);
        bus.lock_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("busy_before_clear", 32'(busy), 32'd1);
        clear_board = 1'b1;
        @(negedge clk);
        clear_board = 1'b0;
        check("clr_busy", 32'(busy), 32'd0);
        check("clr_score", 32'(score_bcd), 32'h0000);
        check("clr_lines", 32'(lines_cleared), 32'd0);
        done_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (clear_done) done_seen = 1'b1;
        end
        check("clr_no_done", 32'(done_seen), 32'd0);
        count_nonzero(0, 19, n);
        check("clr_board_empty", 32'(n), 32'd0);

        // reset_n during the scan.
        write_cell(4'd2, 5'd5, 4'd3);
        @(negedge clk);
        bus.lock_valid = 1'b1;
        @(negedge clk);
        bus.lock_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("busy_in_scan", 32'(busy), 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("rst_busy", 32'(busy), 32'd0);
        read_cell(4'd2, 5'd5, k);
        check("rst_cell", 32'(k), 32'd0);
        count_nonzero(0, 19, n);
        check("rst_board_empty", 32'(n), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
